// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU: instruction field layout, key opcodes
// and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int INSTR_W  = 10;
  localparam int OPC_MSB  = 9;
  localparam int OPC_LSB  = 6;
  localparam int OPC_W    = OPC_MSB - OPC_LSB + 1;
  localparam int JTGT_MSB = 5;
  localparam int JTGT_LSB = 0;
  localparam int BOFF_MSB = 3;
  localparam int BOFF_LSB = 0;
  localparam int BOFF_W   = BOFF_MSB - BOFF_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for an issuing instruction: jump target,
// PC-relative branch or fall-through, all modulo 2^PC_W.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               jump,
  input  logic               beq,
  input  logic               bne,
  input  logic               zero,
  output logic [PC_W-1:0]    next_pc,
  output logic               taken
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] boff_ext;
  logic            branch_taken;
  logic            unused_opc;

  // Opcode bits are decoded by Control; only the target/offset fields matter here.
  assign unused_opc = ^instr[OPC_MSB:OPC_LSB];

  assign seq_pc       = pc + PC_W'(1);
  assign boff_ext     = {{(PC_W-BOFF_W){instr[BOFF_MSB]}}, instr[BOFF_MSB:BOFF_LSB]};
  assign branch_taken = (beq & zero) | (bne & ~zero);
  assign taken        = jump | branch_taken;

  always_comb begin
    // NOTE: next_pc gets a default before the priority chain so no latch is inferred.
    next_pc = seq_pc;
    if (jump) begin
      next_pc = PC_W'(instr[JTGT_MSB:JTGT_LSB]);
    end else if (branch_taken) begin
      next_pc = seq_pc + boff_ext;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: fetches from instruction memory, presents
// OPCODE to Control and resolves the next PC from Control's redirect outputs.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic [PC_W-1:0]    IMEM_ADDR,
  output logic               IMEM_REQ,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  input  logic               IMEM_VALID,
  input  logic               STALL,
  input  logic               JUMP,
  input  logic               BEQ,
  input  logic               BNE,
  input  logic               HALT,
  input  logic               ZERO,
  input  logic               RESUME,
  output logic [OPC_W-1:0]   OPCODE,
  output logic [INSTR_W-1:0] INSTR,
  output logic               ISSUE,
  output logic [PC_W-1:0]    PC,
  output logic               HALTED
);

  seq_state_t         state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [OPC_W-1:0]   opcode_q;
  logic               issue_q;
  logic               halted_q;
  logic               req_q;

  logic [PC_W-1:0]    pc_seq;
  logic [PC_W-1:0]    calc_pc;
  logic               calc_taken;

  assign pc_seq = pc_q + PC_W'(1);

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc      (pc_q),
    .instr   (instr_q),
    .jump    (JUMP),
    .beq     (BEQ),
    .bne     (BNE),
    .zero    (ZERO),
    .next_pc (calc_pc),
    .taken   (calc_taken)
  );

  // Outputs are registered alongside the state so nothing downstream sees a
  // combinational path from STALL, IMEM_VALID or the Control inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      opcode_q <= OPC_NOP;
      issue_q  <= 1'b0;
      halted_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block order-independent.
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
          req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (IMEM_VALID) begin
            instr_q  <= IMEM_DATA;
            opcode_q <= IMEM_DATA[OPC_MSB:OPC_LSB];
            issue_q  <= 1'b1;
            req_q    <= 1'b0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!STALL) begin
            issue_q  <= 1'b0;
            opcode_q <= OPC_NOP;
            if (HALT) begin
              pc_q     <= pc_seq;
              halted_q <= 1'b1;
              state    <= ST_HALTED;
            end else begin
              pc_q  <= calc_taken ? calc_pc : pc_seq;
              req_q <= 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          if (RESUME) begin
            halted_q <= 1'b0;
            req_q    <= 1'b1;
            state    <= ST_FETCH;
          end
        end
      endcase
    end
  end

  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign IMEM_REQ  = req_q;
  assign OPCODE    = opcode_q;
  assign INSTR     = instr_q;
  assign ISSUE     = issue_q;
  assign HALTED    = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected fetches and
// issues, a negedge monitor pops and compares them as the DUT presents them.
module tb_fetch_sequencer;

  localparam int PC_W = 10;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [PC_W-1:0] IMEM_ADDR;
  logic            IMEM_REQ;
  logic [9:0]      IMEM_DATA;
  logic            IMEM_VALID;
  logic            STALL, JUMP, BEQ, BNE, HALT, ZERO, RESUME;
  logic [3:0]      OPCODE;
  logic [9:0]      INSTR;
  logic            ISSUE;
  logic [PC_W-1:0] PC;
  logic            HALTED;

  fetch_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_DATA  (IMEM_DATA),
    .IMEM_VALID (IMEM_VALID),
    .STALL      (STALL),
    .JUMP       (JUMP),
    .BEQ        (BEQ),
    .BNE        (BNE),
    .HALT       (HALT),
    .ZERO       (ZERO),
    .RESUME     (RESUME),
    .OPCODE     (OPCODE),
    .INSTR      (INSTR),
    .ISSUE      (ISSUE),
    .PC         (PC),
    .HALTED     (HALTED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [3:0]      opc;
    logic [9:0]      instr;
  } issue_rec_t;

  logic [PC_W-1:0] fetch_q[$];
  issue_rec_t      issue_q[$];
  logic [PC_W-1:0] f_exp;
  issue_rec_t      i_exp;

  int n_checks = 0;
  int n_pass   = 0;
  int req_cycles   = 0;
  int issue_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: accepted fetches and retiring issues are compared against the queues.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (IMEM_REQ) req_cycles++;
      if (ISSUE) issue_cycles++;
      if (IMEM_REQ && IMEM_VALID) begin
        if (fetch_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_fetch: got addr 0x%0h, expected no fetch", IMEM_ADDR);
        end else begin
          f_exp = fetch_q.pop_front();
          check("fetch_addr", IMEM_ADDR, f_exp);
        end
      end
      if (ISSUE && !STALL) begin
        if (issue_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_issue: got pc 0x%0h, expected no issue", PC);
        end else begin
          i_exp = issue_q.pop_front();
          check("issue_pc", PC, i_exp.pc);
          check("issue_opcode", OPCODE, i_exp.opc);
          check("issue_instr", INSTR, i_exp.instr);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, IMEM_ADDR, 10'h000);
    check({tag, "_imem_req"}, IMEM_REQ, 1'b0);
    check({tag, "_issue"}, ISSUE, 1'b0);
    check({tag, "_opcode"}, OPCODE, 4'h0);
    check({tag, "_instr"}, INSTR, 10'h000);
    check({tag, "_pc"}, PC, 10'h000);
    check({tag, "_halted"}, HALTED, 1'b0);
  endtask

  // One instruction: fetch at addr (after wait_cyc memory-wait cycles), then
  // issue with stall_cyc stall cycles, then present the Control decode.
  task automatic do_instr(input logic [PC_W-1:0] addr, input logic [9:0] data,
                          input int wait_cyc, input int stall_cyc,
                          input logic halt, input logic jump, input logic beq,
                          input logic bne, input logic zero);
    issue_rec_t rec;
    int t;
    rec.pc = addr;
    rec.opc = data[9:6];
    rec.instr = data;
    fetch_q.push_back(addr);
    issue_q.push_back(rec);
    t = 0;
    while (!IMEM_REQ && t < 20) begin
      step();
      t++;
    end
    if (!IMEM_REQ) check("fetch_req_timeout", IMEM_REQ, 1'b1);
    req_cycles = 0;
    issue_cycles = 0;
    repeat (wait_cyc) step();
    IMEM_VALID = 1'b1;
    IMEM_DATA  = data;
    step();
    IMEM_VALID = 1'b0;
    IMEM_DATA  = 10'h3FF;
    check("issue_start", ISSUE, 1'b1);
    // Misleading Control values during the stall must be ignored.
    STALL = 1'b1;
    HALT  = 1'b1;
    JUMP  = 1'b1;
    repeat (stall_cyc) begin
      step();
      check("stall_pc_hold", PC, addr);
    end
    STALL = 1'b0;
    HALT = halt; JUMP = jump; BEQ = beq; BNE = bne; ZERO = zero;
    step();
    HALT = 1'b0; JUMP = 1'b0; BEQ = 1'b0; BNE = 1'b0; ZERO = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b1;
    IMEM_DATA = '0; IMEM_VALID = 1'b0; STALL = 1'b0; JUMP = 1'b0;
    BEQ = 1'b0; BNE = 1'b0; HALT = 1'b0; ZERO = 1'b0; RESUME = 1'b0;
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) step();
    RST_N = 1'b1;

    // Sequential fetch, memory responding in the same cycle.
    do_instr(10'h000, 10'h080, 0, 0, 0, 0, 0, 0, 0);
    do_instr(10'h001, 10'h0C0, 0, 0, 0, 0, 0, 0, 0);
    do_instr(10'h002, 10'h100, 0, 0, 0, 0, 0, 0, 0);
    do_instr(10'h003, 10'h140, 0, 0, 0, 0, 0, 0, 0);
    // Jumps: 0x265 at 4 -> 0x25, then back to 5.
    do_instr(10'h004, 10'h265, 0, 0, 0, 1, 0, 0, 0);
    do_instr(10'h025, 10'h205, 0, 0, 0, 1, 0, 0, 0);
    // Branches with offset -2 at PC 5.
    do_instr(10'h005, 10'h18E, 0, 0, 0, 0, 1, 0, 1);
    do_instr(10'h004, 10'h040, 0, 0, 0, 0, 0, 0, 0);
    do_instr(10'h005, 10'h18E, 0, 0, 0, 0, 0, 1, 1);
    do_instr(10'h006, 10'h205, 0, 0, 0, 1, 0, 0, 0);
    do_instr(10'h005, 10'h18E, 0, 0, 0, 0, 0, 1, 0);
    // Three stall cycles: ISSUE held four cycles in total.
    do_instr(10'h004, 10'h0C0, 0, 3, 0, 0, 0, 0, 0);
    check("stall_issue_cycles", issue_cycles, 4);
    check("stall_req_cycles", req_cycles, 1);
    // Memory valid five cycles late: IMEM_REQ held six cycles.
    do_instr(10'h005, 10'h040, 5, 0, 0, 0, 0, 0, 0);
    check("wait_req_cycles", req_cycles, 6);
    check("wait_issue_cycles", issue_cycles, 1);
    // BEQ and BNE together with ZERO=0: taken, offset -1 stays at 6.
    do_instr(10'h006, 10'h1CF, 0, 0, 0, 0, 1, 1, 0);
    // BEQ with ZERO=0: not taken.
    do_instr(10'h006, 10'h18F, 0, 0, 0, 0, 1, 0, 0);
    // HALT together with JUMP: halts with PC advanced to 8.
    do_instr(10'h007, 10'h300, 0, 0, 1, 1, 0, 0, 0);
    check("halt_flag", HALTED, 1'b1);
    check("halt_pc", PC, 10'h008);
    IMEM_VALID = 1'b1;
    repeat (4) begin
      step();
      check("halted_hold", HALTED, 1'b1);
      check("halted_req", IMEM_REQ, 1'b0);
      check("halted_opcode", OPCODE, 4'h0);
      check("halted_issue", ISSUE, 1'b0);
    end
    IMEM_VALID = 1'b0;
    RESUME = 1'b1;
    step();
    RESUME = 1'b0;
    check("resume_halted", HALTED, 1'b0);
    check("resume_req", IMEM_REQ, 1'b1);
    check("resume_addr", IMEM_ADDR, 10'h008);
    // Wrap cases: 0+1-1 stays 0, 0+1-2 gives 0x3FF, 0x3FF+1 gives 0.
    do_instr(10'h008, 10'h200, 0, 0, 0, 1, 0, 0, 0);
    do_instr(10'h000, 10'h18F, 0, 0, 0, 0, 0, 1, 0);
    do_instr(10'h000, 10'h18E, 0, 0, 0, 0, 1, 0, 1);
    do_instr(10'h3FF, 10'h040, 0, 0, 0, 0, 0, 0, 0);
    do_instr(10'h000, 10'h211, 0, 0, 0, 1, 0, 0, 0);
    // Reset in the middle of a FETCH at 0x11.
    step();
    check("pre_reset_req", IMEM_REQ, 1'b1);
    check("pre_reset_addr", IMEM_ADDR, 10'h011);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("mid_reset");
    step();
    RST_N = 1'b1;
    check("idle_req", IMEM_REQ, 1'b0);
    do_instr(10'h000, 10'h080, 0, 0, 0, 0, 0, 0, 0);
    check("post_reset_pc", PC, 10'h001);

    repeat (3) step();
    check("fetch_q_drained", fetch_q.size(), 0);
    check("issue_q_drained", issue_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
